mem_access_unit: RTL

Load/store front end for the ARMv4 core's data port. Accepts one byte, halfword or word request at a time from the execute stage and sequences it into chip-select/enable cycles on the byte-addressable synchronous data RAM. Returns read data with ARMv4 unaligned-word rotation and sign or zero extension applied. Flags misaligned halfword and out-of-range accesses as faults without touching the RAM.

---
 rtl/mem_access_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences one byte/halfword/word load or store onto the
// synchronous data RAM; word loads are rotated, sub-word loads extended.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_input,
    input  logic [DATA_WIDTH-1:0] ram_data_output,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [1:0]            ram_data_size
);

    typedef enum logic [2:0] {
        IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE, RESP
    } state_e;

    state_e state_q, state_d;

    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  oe_q, oe_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic [1:0]            ram_size_q, ram_size_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  fault_q, fault_d;

    logic                  accept;
    logic                  req_fault;
    logic                  cur_write;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [1:0]            cur_size;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic [1:0]            size_code;
    logic [4:0]            rot_sh;
    logic [DATA_WIDTH-1:0] rot_w;
    logic [DATA_WIDTH-1:0] rd_fmt;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && (state_q == IDLE);

    assign req_fault = (req_size == 2'b11)
                     | ((req_size == 2'b01) & req_addr[0])
                     | ((req_addr >> ADDR_WIDTH) != 32'd0);

    // RAM controls are registered, so the issue cycle must see the incoming request
    assign cur_write = accept ? req_write : write_q;
    assign cur_addr  = accept ? req_addr[ADDR_WIDTH-1:0] : addr_q;
    assign cur_size  = accept ? req_size : size_q;
    assign cur_wdata = accept ? req_wdata : wdata_q;

    always_comb begin
        eff_addr = cur_addr;
        if (cur_size == 2'b10) eff_addr[1:0] = 2'b00;
    end

    always_comb begin
        unique case (cur_size)
            2'b00:   size_code = 2'b00;
            2'b01:   size_code = 2'b10;
            default: size_code = 2'b11;
        endcase
    end

    assign rot_sh = {addr_q[1:0], 3'b000};
    assign rot_w  = DATA_WIDTH'({ram_data_output, ram_data_output} >> rot_sh);

    always_comb begin
        unique case (size_q)
            2'b00: rd_fmt = {{(DATA_WIDTH-8){signed_q & ram_data_output[7]}},
                             ram_data_output[7:0]};
            2'b01: rd_fmt = {{(DATA_WIDTH-16){signed_q & ram_data_output[15]}},
                             ram_data_output[15:0]};
            default: rd_fmt = rot_w;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_fault)      state_d = RESP;
                    else if (req_write) state_d = WR_ISSUE;
                    else                state_d = RD_ISSUE;
                end
            end
            RD_ISSUE:   state_d = RD_CAPTURE;
            RD_CAPTURE: state_d = RESP;
            WR_ISSUE:   state_d = RESP;
            RESP:       if (resp_ready) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        cs_d         = (state_d == RD_ISSUE) || (state_d == RD_CAPTURE)
                    || (state_d == WR_ISSUE);
        we_d         = cs_d && cur_write;
        oe_d         = cs_d && !cur_write;
        ram_addr_d   = cs_d ? eff_addr : '0;
        ram_size_d   = cs_d ? size_code : 2'b00;
        ram_wdata_d  = we_d ? cur_wdata : '0;
        resp_valid_d = (state_d == RESP);
        rdata_d      = '0;
        fault_d      = 1'b0;
        if (state_d == RESP) begin
            rdata_d = (state_q == RD_CAPTURE) ? rd_fmt : rdata_q;
            fault_d = (state_q == IDLE) || fault_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            addr_q       <= '0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            wdata_q      <= '0;
            cs_q         <= 1'b0;
            we_q         <= 1'b0;
            oe_q         <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_size_q   <= 2'b00;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q  <= req_write;
                addr_q   <= req_addr[ADDR_WIDTH-1:0];
                size_q   <= req_size;
                signed_q <= req_signed;
                wdata_q  <= req_wdata;
            end
            cs_q         <= cs_d;
            we_q         <= we_d;
            oe_q         <= oe_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_size_q   <= ram_size_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            fault_q      <= fault_d;
        end
    end

    assign ram_cs         = cs_q;
    assign ram_we         = we_q;
    assign ram_oe         = oe_q;
    assign ram_address    = ram_addr_q;
    assign ram_data_input = ram_wdata_q;
    assign ram_data_size  = ram_size_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = rdata_q;
    assign resp_fault     = fault_q;

endmodule
